// File: rtl/multi_interval_timer_pkg.sv
// Shared register offsets and bit positions for the multi-channel interval timer.
// The address of a register is {channel, offset}.
package multi_interval_timer_pkg;

    localparam logic [2:0] REG_STATUS   = 3'd0;
    localparam logic [2:0] REG_CONTROL  = 3'd1;
    localparam logic [2:0] REG_PERIOD_L = 3'd2;
    localparam logic [2:0] REG_PERIOD_H = 3'd3;
    localparam logic [2:0] REG_SNAP_L   = 3'd4;
    localparam logic [2:0] REG_SNAP_H   = 3'd5;
    localparam logic [2:0] REG_PRESCALE = 3'd6;
    localparam logic [2:0] REG_IRQ_PEND = 3'd7;

    localparam int unsigned STATUS_TO_BIT  = 0;
    localparam int unsigned STATUS_RUN_BIT = 1;

    localparam int unsigned CTRL_ITO_BIT   = 0;
    localparam int unsigned CTRL_CONT_BIT  = 1;
    localparam int unsigned CTRL_START_BIT = 2;
    localparam int unsigned CTRL_STOP_BIT  = 3;

endpackage

// File: rtl/multi_interval_timer_if.sv
// Avalon-MM style slave bus used by the interval timer.
interface multi_interval_timer_if #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] address;
    logic                  chipselect;
    logic                  write_n;
    logic [DATA_WIDTH-1:0] writedata;
    logic [DATA_WIDTH-1:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/multi_interval_timer_channel.sv
// One timer channel: prescaler, down-counter, run/timeout state, snapshot and config registers.
// Driven by per-register write strobes decoded in the top level.
module multi_interval_timer_channel
    import multi_interval_timer_pkg::*;
#(
    parameter int unsigned              DATA_WIDTH     = 16,
    parameter int unsigned              COUNTER_WIDTH  = 32,
    parameter int unsigned              PRESCALE_WIDTH = 8,
    parameter logic [COUNTER_WIDTH-1:0] RESET_PERIOD   = '0
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      i_wr_status,
    input  logic                      i_wr_control,
    input  logic                      i_wr_period_l,
    input  logic                      i_wr_period_h,
    input  logic                      i_wr_snap,
    input  logic                      i_wr_prescale,
    input  logic [DATA_WIDTH-1:0]     i_wdata,
    output logic                      o_to,
    output logic                      o_run,
    output logic                      o_ito,
    output logic                      o_cont,
    output logic [COUNTER_WIDTH-1:0]  o_period,
    output logic [COUNTER_WIDTH-1:0]  o_snap,
    output logic [PRESCALE_WIDTH-1:0] o_prescale,
    output logic                      o_irq
);
    localparam int unsigned HI_W = COUNTER_WIDTH - DATA_WIDTH;

    logic                      r_ito, r_cont, r_run, r_to, r_zero_d, r_force_reload;
    logic [COUNTER_WIDTH-1:0]  r_period, r_counter, r_snap;
    logic [PRESCALE_WIDTH-1:0] r_prescale, r_pre_cnt;

    logic w_start, w_stop, w_tick, w_zero, w_last, w_event, w_oneshot_end;

    assign w_start       = i_wr_control & i_wdata[CTRL_START_BIT];
    assign w_stop        = i_wr_control & i_wdata[CTRL_STOP_BIT];
    assign w_tick        = r_run & (r_pre_cnt == '0);
    assign w_zero        = (r_counter == '0);
    assign w_last        = w_zero | (r_counter == COUNTER_WIDTH'(1));
    assign w_event       = w_zero & ~r_zero_d;
    // One-shot stops on the tick that lands on zero so the counter never reloads.
    assign w_oneshot_end = w_tick & ~r_cont & w_last;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_ito          <= 1'b0;
            r_cont         <= 1'b0;
            r_run          <= 1'b0;
            r_to           <= 1'b0;
            r_zero_d       <= 1'b0;
            r_force_reload <= 1'b0;
            r_period       <= RESET_PERIOD;
            r_counter      <= RESET_PERIOD;
            r_snap         <= '0;
            r_prescale     <= '0;
            r_pre_cnt      <= '0;
        end else begin
            r_force_reload <= i_wr_period_l | i_wr_period_h;
            if (i_wr_period_l) r_period[DATA_WIDTH-1:0] <= i_wdata;
            if (i_wr_period_h) r_period[COUNTER_WIDTH-1:DATA_WIDTH] <= i_wdata[HI_W-1:0];
            if (i_wr_control) begin
                r_ito  <= i_wdata[CTRL_ITO_BIT];
                r_cont <= i_wdata[CTRL_CONT_BIT];
            end
            if (i_wr_prescale) r_prescale <= i_wdata[PRESCALE_WIDTH-1:0];
            if (i_wr_snap) r_snap <= r_counter;

            if (r_force_reload || w_start || w_tick) begin
                r_pre_cnt <= r_prescale;
            end else if (r_run) begin
                r_pre_cnt <= r_pre_cnt - PRESCALE_WIDTH'(1);
            end

            if (r_force_reload) begin
                r_counter <= r_period;
            end else if (w_tick) begin
                if (w_oneshot_end)  r_counter <= '0;
                else if (w_zero)    r_counter <= r_period;
                else                r_counter <= r_counter - COUNTER_WIDTH'(1);
            end

            if (r_force_reload)                r_run <= 1'b0;
            else if (w_start)                  r_run <= 1'b1;
            else if (w_stop || w_oneshot_end)  r_run <= 1'b0;

            r_zero_d <= w_zero;
            if (i_wr_status)   r_to <= 1'b0;
            else if (w_event)  r_to <= 1'b1;
        end
    end

    assign o_to       = r_to;
    assign o_run      = r_run;
    assign o_ito      = r_ito;
    assign o_cont     = r_cont;
    assign o_period   = r_period;
    assign o_snap     = r_snap;
    assign o_prescale = r_prescale;
    assign o_irq      = r_to & r_ito;
endmodule

// File: rtl/multi_interval_timer.sv
// Multi-channel interval timer: bus decode, registered read mux and interrupt combine
// around NUM_CH independent timer channels.
module multi_interval_timer
    import multi_interval_timer_pkg::*;
#(
    parameter int unsigned              NUM_CH         = 4,
    parameter int unsigned              DATA_WIDTH     = 16,
    parameter int unsigned              COUNTER_WIDTH  = 32,
    parameter int unsigned              PRESCALE_WIDTH = 8,
    parameter logic [COUNTER_WIDTH-1:0] RESET_PERIOD   = COUNTER_WIDTH'(32'h7A11F)
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    multi_interval_timer_if.slave io_bus,
    output logic                  o_irq,
    output logic [NUM_CH-1:0]     o_irq_vector
);
    localparam int unsigned ADDR_WIDTH = $clog2(NUM_CH) + 3;

    logic                      w_wr;
    logic [2:0]                w_reg;
    logic [ADDR_WIDTH-1:0]     w_ch;
    logic [NUM_CH-1:0]         w_sel, w_to, w_run, w_ito, w_cont, w_irq_vec;
    logic [COUNTER_WIDTH-1:0]  w_period [NUM_CH];
    logic [COUNTER_WIDTH-1:0]  w_snap [NUM_CH];
    logic [PRESCALE_WIDTH-1:0] w_prescale [NUM_CH];
    logic [DATA_WIDTH-1:0]     w_rdata, r_readdata;

    assign w_wr  = io_bus.chipselect & ~io_bus.write_n;
    assign w_reg = io_bus.address[2:0];
    assign w_ch  = io_bus.address >> 3;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Channel codes beyond NUM_CH never match, so those writes fall on the floor.
        assign w_sel[i] = w_wr & (w_ch == ADDR_WIDTH'(i));

        multi_interval_timer_channel #(
            .DATA_WIDTH     (DATA_WIDTH),
            .COUNTER_WIDTH  (COUNTER_WIDTH),
            .PRESCALE_WIDTH (PRESCALE_WIDTH),
            .RESET_PERIOD   (RESET_PERIOD)
        ) u_channel (
            .i_clk         (i_clk),
            .i_reset_n     (i_reset_n),
            .i_wr_status   (w_sel[i] && (w_reg == REG_STATUS)),
            .i_wr_control  (w_sel[i] && (w_reg == REG_CONTROL)),
            .i_wr_period_l (w_sel[i] && (w_reg == REG_PERIOD_L)),
            .i_wr_period_h (w_sel[i] && (w_reg == REG_PERIOD_H)),
            .i_wr_snap     (w_sel[i] && ((w_reg == REG_SNAP_L) || (w_reg == REG_SNAP_H))),
            .i_wr_prescale (w_sel[i] && (w_reg == REG_PRESCALE)),
            .i_wdata       (io_bus.writedata),
            .o_to          (w_to[i]),
            .o_run         (w_run[i]),
            .o_ito         (w_ito[i]),
            .o_cont        (w_cont[i]),
            .o_period      (w_period[i]),
            .o_snap        (w_snap[i]),
            .o_prescale    (w_prescale[i]),
            .o_irq         (w_irq_vec[i])
        );
    end

    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_ch == ADDR_WIDTH'(i)) begin
                case (w_reg)
                    REG_STATUS: begin
                        w_rdata[STATUS_TO_BIT]  = w_to[i];
                        w_rdata[STATUS_RUN_BIT] = w_run[i];
                    end
                    REG_CONTROL: begin
                        w_rdata[CTRL_ITO_BIT]  = w_ito[i];
                        w_rdata[CTRL_CONT_BIT] = w_cont[i];
                    end
                    REG_PERIOD_L: w_rdata = w_period[i][DATA_WIDTH-1:0];
                    REG_PERIOD_H: w_rdata = DATA_WIDTH'(w_period[i][COUNTER_WIDTH-1:DATA_WIDTH]);
                    REG_SNAP_L:   w_rdata = w_snap[i][DATA_WIDTH-1:0];
                    REG_SNAP_H:   w_rdata = DATA_WIDTH'(w_snap[i][COUNTER_WIDTH-1:DATA_WIDTH]);
                    REG_PRESCALE: w_rdata = DATA_WIDTH'(w_prescale[i]);
                    REG_IRQ_PEND: w_rdata = DATA_WIDTH'(w_irq_vec);
                    default:      w_rdata = '0;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) r_readdata <= '0;
        else            r_readdata <= w_rdata;
    end

    assign io_bus.readdata = r_readdata;
    assign o_irq_vector    = w_irq_vec;
    assign o_irq           = |w_irq_vec;
endmodule

// File: tb/tb_multi_interval_timer.sv
// Self-checking bench for multi_interval_timer: register table plus timed sequences
// for timeout period, clear/timeout collision, one-shot, reload-on-period-write and snapshot.
module tb_multi_interval_timer;
    import multi_interval_timer_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       irq;
    logic [3:0] irq_vec;
    int         n_checks = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         last_cap = 0;
    int         s, t;

    typedef struct {
        string       name;
        logic [15:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        bit          wr;
        logic [1:0]  ch;
        logic [2:0]  rg;
        logic [15:0] data;
        string       name;
    } vec_t;
    vec_t vecs[$];

    multi_interval_timer_if #(.ADDR_WIDTH(5), .DATA_WIDTH(16)) bus_if ();

    multi_interval_timer #(
        .NUM_CH         (4),
        .DATA_WIDTH     (16),
        .COUNTER_WIDTH  (32),
        .PRESCALE_WIDTH (8)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .io_bus       (bus_if),
        .o_irq        (irq),
        .o_irq_vector (irq_vec)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write is captured on the posedge after the next negedge; last_cap holds that cycle.
    task automatic bus_wr(input logic [1:0] ch, input logic [2:0] rg, input logic [15:0] d);
        @(negedge clk);
        bus_if.address    = {ch, rg};
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b0;
        bus_if.writedata  = d;
        last_cap          = cyc + 1;
        @(negedge clk);
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
    endtask

    task automatic bus_rd(input logic [1:0] ch, input logic [2:0] rg, input logic [15:0] exp,
                          input string name);
        sb_t e;
        @(negedge clk);
        bus_if.address    = {ch, rg};
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b1;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        bus_if.chipselect = 1'b0;
        e = sb_q.pop_front();
        check(e.name, 32'(bus_if.readdata), 32'(e.exp));
    endtask

    task automatic wait_neg(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic add(input bit wr, input logic [1:0] ch, input logic [2:0] rg,
                       input logic [15:0] d, input string name);
        vec_t v;
        v.wr = wr; v.ch = ch; v.rg = rg; v.data = d; v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        bus_if.address    = '0;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.writedata  = '0;

        add(0, 2'd0, REG_PERIOD_L, 16'hA11F, "rst_period_l");
        add(0, 2'd0, REG_PERIOD_H, 16'h0007, "rst_period_h");
        add(0, 2'd0, REG_STATUS,   16'h0000, "rst_status");
        add(0, 2'd3, REG_CONTROL,  16'h0000, "rst_control");
        add(0, 2'd1, REG_SNAP_L,   16'h0000, "rst_snap_l");
        add(0, 2'd1, REG_SNAP_H,   16'h0000, "rst_snap_h");
        add(0, 2'd2, REG_PRESCALE, 16'h0000, "rst_prescale");
        add(0, 2'd0, REG_IRQ_PEND, 16'h0000, "rst_irq_pend");
        add(1, 2'd2, REG_PRESCALE, 16'h01AB, "");
        add(0, 2'd2, REG_PRESCALE, 16'h00AB, "prescale_trunc");
        add(0, 2'd0, REG_PRESCALE, 16'h0000, "prescale_isolate");
        add(1, 2'd3, REG_CONTROL,  16'h0003, "");
        add(0, 2'd3, REG_CONTROL,  16'h0003, "control_rb");
        add(0, 2'd3, REG_STATUS,   16'h0000, "control_no_run");
        add(1, 2'd3, REG_CONTROL,  16'h0000, "");
        add(1, 2'd1, REG_PERIOD_H, 16'h1234, "");
        add(0, 2'd1, REG_PERIOD_H, 16'h1234, "period_h_rb");
        add(0, 2'd1, REG_PERIOD_L, 16'hA11F, "period_l_kept");
        add(0, 2'd0, REG_PERIOD_H, 16'h0007, "period_isolate");

        repeat (3) @(negedge clk);
        check("irq_in_reset", 32'(irq), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) bus_wr(vecs[i].ch, vecs[i].rg, vecs[i].data);
            else            bus_rd(vecs[i].ch, vecs[i].rg, vecs[i].data, vecs[i].name);
        end

        // ch1: period 9, prescale 0, continuous, START|STOP together.
        bus_wr(2'd1, REG_PERIOD_L, 16'd9);
        bus_wr(2'd1, REG_PERIOD_H, 16'd0);
        bus_wr(2'd1, REG_PRESCALE, 16'd0);
        bus_wr(2'd1, REG_CONTROL,  16'h0003);
        bus_wr(2'd1, REG_CONTROL,  16'h000F);
        s = last_cap;
        wait_neg(s + 9);
        check("to_not_yet", 32'(irq), 32'h0);
        wait_neg(s + 10);
        check("to_at_10", 32'(irq), 32'h1);
        check("vec_ch1", 32'(irq_vec), 32'h2);
        wait_neg(s + 18);
        bus_wr(2'd1, REG_STATUS, 16'h0000);
        check("clear_cap_cycle", last_cap, s + 20);
        check("clear_wins", 32'(irq), 32'h0);
        bus_rd(2'd1, REG_STATUS, 16'h0002, "run_after_clear");
        wait_neg(s + 29);
        check("to_not_yet2", 32'(irq), 32'h0);
        wait_neg(s + 30);
        check("to_period", 32'(irq), 32'h1);

        // ch2: one-shot, period 3, prescale 4.
        bus_wr(2'd2, REG_PERIOD_L, 16'd3);
        bus_wr(2'd2, REG_PERIOD_H, 16'd0);
        bus_wr(2'd2, REG_PRESCALE, 16'd4);
        bus_wr(2'd2, REG_CONTROL,  16'h0005);
        t = last_cap;
        wait_neg(t + 10);
        check("oneshot_early", 32'(irq_vec[2]), 32'h0);
        wait_neg(t + 25);
        check("oneshot_to", 32'(irq_vec[2]), 32'h1);
        bus_rd(2'd2, REG_STATUS, 16'h0001, "oneshot_stopped");
        bus_wr(2'd2, REG_SNAP_L, 16'h0000);
        bus_rd(2'd2, REG_SNAP_L, 16'h0000, "oneshot_cnt_zero");
        bus_wr(2'd2, REG_STATUS, 16'h0000);
        wait_neg(cyc + 20);
        bus_rd(2'd2, REG_STATUS, 16'h0000, "oneshot_single");

        // ch0: period write while running reloads next clock and stops.
        bus_wr(2'd0, REG_CONTROL,  16'h0004);
        bus_wr(2'd0, REG_PERIOD_H, 16'h0000);
        bus_wr(2'd0, REG_CONTROL,  16'h0004);
        repeat (5) @(negedge clk);
        bus_wr(2'd0, REG_PERIOD_L, 16'h0050);
        bus_wr(2'd0, REG_SNAP_L,   16'h0000);
        bus_rd(2'd0, REG_SNAP_L,   16'h0050, "reload_value");
        bus_rd(2'd0, REG_SNAP_H,   16'h0000, "reload_value_h");
        bus_rd(2'd0, REG_STATUS,   16'h0000, "reload_stops");
        bus_wr(2'd0, REG_CONTROL,  16'h0004);
        t = last_cap;
        wait_neg(t + 4);
        bus_wr(2'd0, REG_SNAP_H, 16'h0000);
        bus_rd(2'd0, REG_SNAP_L, 16'(16'h0050 - (last_cap - t - 1)), "resume_from_period");

        // ch3 interrupting, ch1 timed out with ITO off.
        bus_wr(2'd2, REG_CONTROL,  16'h0000);
        bus_wr(2'd1, REG_CONTROL,  16'h0002);
        bus_wr(2'd3, REG_PERIOD_L, 16'd2);
        bus_wr(2'd3, REG_PERIOD_H, 16'd0);
        bus_wr(2'd3, REG_PRESCALE, 16'd0);
        bus_wr(2'd3, REG_CONTROL,  16'h0005);
        wait_neg(cyc + 10);
        bus_rd(2'd0, REG_IRQ_PEND, 16'h0008, "irq_pend");
        check("irq_or", 32'(irq), 32'h1);
        check("irq_vec", 32'(irq_vec), 32'h8);
        bus_rd(2'd1, REG_STATUS, 16'h0003, "ch1_to_masked");
        bus_rd(2'd3, REG_STATUS, 16'h0001, "ch3_to");
        bus_wr(2'd1, REG_SNAP_L, 16'h0000);
        bus_rd(2'd1, REG_SNAP_L, 16'(9 - ((last_cap - 1 - s) % 10)), "snap_running");

        // Asynchronous reset mid-count.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_irq", 32'(irq), 32'h0);
        check("async_vec", 32'(irq_vec), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus_rd(2'd1, REG_STATUS,   16'h0000, "post_rst_status");
        bus_rd(2'd1, REG_PERIOD_L, 16'hA11F, "post_rst_period");
        bus_rd(2'd3, REG_CONTROL,  16'h0000, "post_rst_control");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
